// File: rtl/rubik_rd_cdt_ctrl.sv
// Credit-based 64B DMA read-request sequencer for the rubik read-response path.
// A request is presented only while a response FIFO entry is guaranteed free;
// credits come back through rd_cdt_lat_fifo_pop.
module rubik_rd_cdt_ctrl #(
  parameter int unsigned CDT_DEPTH = 128,
  parameter int unsigned CDT_W     = 8,
  parameter int unsigned LEN_W     = 13
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              op_en,
  input  logic [LEN_W-1:0]  op_req_num,
  input  logic [63:0]       op_base_addr,
  output logic              dma_rd_req_vld,
  output logic [78:0]       dma_rd_req_pd,
  input  logic              dma_rd_req_rdy,
  input  logic              rd_cdt_lat_fifo_pop,
  output logic              op_busy,
  output logic              op_done,
  output logic [CDT_W-1:0]  cdt_avail,
  output logic              cdt_err
);

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned SIZE_W = 15;
  localparam int unsigned PD_W   = SIZE_W + ADDR_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // one request moves two 32B atoms; the size field encodes atoms minus one
  localparam logic [SIZE_W-1:0] REQ_SIZE  = SIZE_W'(1);
  localparam logic [ADDR_W-1:0] REQ_BYTES = ADDR_W'(64);
  localparam logic [CDT_W-1:0]  CDT_MAX   = CDT_W'(CDT_DEPTH);

  logic [1:0]        state_q,  state_d;
  logic [CDT_W-1:0]  credit_q, credit_d;
  logic [CDT_W-1:0]  outst_q,  outst_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic              vld_q,    vld_d;
  logic [PD_W-1:0]   pd_q,     pd_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic              err_q,    err_d;

  logic accept;
  logic hold;
  logic credit_full;

  // State and output registers; reset aborts any operation without a done pulse
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q  <= ST_IDLE;
      credit_q <= CDT_MAX;
      outst_q  <= '0;
      remain_q <= '0;
      addr_q   <= '0;
      vld_q    <= 1'b0;
      pd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      outst_q  <= outst_d;
      remain_q <= remain_d;
      addr_q   <= addr_d;
      vld_q    <= vld_d;
      pd_q     <= pd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state, credit/outstanding bookkeeping and request presentation
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    outst_d     = outst_q;
    remain_d    = remain_q;
    addr_d      = addr_q;
    vld_d       = 1'b0;
    pd_d        = pd_q;
    err_d       = err_q;
    accept      = vld_q & dma_rd_req_rdy;
    hold        = vld_q & ~dma_rd_req_rdy;
    credit_full = (credit_q == CDT_MAX);

    // an accept and a pop in the same cycle cancel on both counters
    if (accept && !rd_cdt_lat_fifo_pop) begin
      credit_d = credit_q - CDT_W'(1);
      outst_d  = outst_q + CDT_W'(1);
    end else if (!accept && rd_cdt_lat_fifo_pop) begin
      if (credit_full) begin
        err_d = 1'b1;
      end else begin
        credit_d = credit_q + CDT_W'(1);
      end
      if (outst_q != '0) begin
        outst_d = outst_q - CDT_W'(1);
      end
    end

    if (accept) begin
      remain_d = remain_q - LEN_W'(1);
      addr_d   = addr_q + REQ_BYTES;
    end

    case (state_q)
      ST_IDLE: begin
        if (op_en) begin
          addr_d   = op_base_addr;
          remain_d = op_req_num;
          state_d  = (op_req_num == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && (remain_q == LEN_W'(1))) begin
          state_d = (outst_d == '0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outst_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // a presented request stays put until taken; after an accept the next one
    // follows immediately if work and credit (pop included) remain
    if (hold) begin
      vld_d = 1'b1;
    end else if (accept) begin
      vld_d = (remain_d != '0) && (credit_d != '0);
    end else begin
      vld_d = (state_q == ST_RUN) && (remain_q != '0) && (credit_q != '0);
    end

    if (vld_d && !hold) begin
      pd_d = {REQ_SIZE, addr_d};
    end
  end

  assign busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  assign done_d = (state_d == ST_DONE);

  assign dma_rd_req_vld = vld_q;
  assign dma_rd_req_pd  = pd_q;
  assign op_busy        = busy_q;
  assign op_done        = done_q;
  assign cdt_avail      = credit_q;
  assign cdt_err        = err_q;

endmodule

// File: tb/tb_rubik_rd_cdt_ctrl.sv
// Bench for rubik_rd_cdt_ctrl: directed scenarios plus randomized operations,
// all checked every cycle against a transaction-level credit/address model.
module tb_rubik_rd_cdt_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 8;
  localparam int unsigned LW    = 13;

  logic          clk;
  logic          rst_n;
  logic          op_en;
  logic [LW-1:0] op_req_num;
  logic [63:0]   op_base_addr;
  logic          vld;
  logic [78:0]   pd;
  logic          rdy;
  logic          pop;
  logic          busy;
  logic          done;
  logic [CW-1:0] avail;
  logic          err;

  rubik_rd_cdt_ctrl #(.CDT_DEPTH(DEPTH), .CDT_W(CW), .LEN_W(LW)) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rstn     (rst_n),
    .op_en               (op_en),
    .op_req_num          (op_req_num),
    .op_base_addr        (op_base_addr),
    .dma_rd_req_vld      (vld),
    .dma_rd_req_pd       (pd),
    .dma_rd_req_rdy      (rdy),
    .rd_cdt_lat_fifo_pop (pop),
    .op_busy             (busy),
    .op_done             (done),
    .cdt_avail           (avail),
    .cdt_err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // stimulus controls
  logic rdy_rand = 1'b0;
  logic rdy_fix  = 1'b1;
  logic ret_on   = 1'b0;
  logic pop_force = 1'b0;
  logic pop_raw  = 1'b0;
  int   ret_min  = 5;
  int   ret_max  = 5;
  int   cyc      = 0;
  int   acc_cnt  = 0;
  int   done_cnt = 0;
  int   ret_q[$];

  // reference model: credit pool, outstanding reads, current operation
  int          m_credit = DEPTH;
  int          m_out    = 0;
  logic        m_err    = 1'b0;
  logic        m_active = 1'b0;
  logic        m_in_done = 1'b0;
  int          m_total  = 0;
  int          m_issued = 0;
  logic [63:0] exp_addr = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // one clock: drive rdy/pop, advance the model, step the clock, compare
  task automatic tick();
    logic        acc;
    logic        p;
    logic        hold;
    logic        done_exp;
    logic [78:0] pd_pre;
    p = pop_raw;
    if (!p && ret_q.size() > 0 && (pop_force || (ret_on && ret_q[0] <= cyc))) begin
      p = 1'b1;
      void'(ret_q.pop_front());
    end
    rdy    = rdy_rand ? 1'($urandom % 2) : rdy_fix;
    pop    = p;
    acc    = vld && rdy;
    hold   = vld && !rdy;
    pd_pre = pd;
    if (acc) begin
      chk("req_pd", 128'(pd), 128'({15'd1, exp_addr}));
      exp_addr = exp_addr + 64'd64;
      m_issued++;
      acc_cnt++;
      ret_q.push_back(cyc + $urandom_range(ret_max, ret_min));
    end
    if (acc && !p) begin
      m_credit--;
      m_out++;
    end else if (!acc && p) begin
      if (m_credit == DEPTH) m_err = 1'b1;
      else m_credit++;
      if (m_out > 0) m_out--;
    end
    done_exp = 1'b0;
    if (m_active && m_issued == m_total && m_out == 0) begin
      m_active = 1'b0;
      done_exp = 1'b1;
    end else if (op_en && !m_active && !m_in_done) begin
      m_total  = int'(op_req_num);
      m_issued = 0;
      exp_addr = op_base_addr;
      if (m_total == 0) done_exp = 1'b1;
      else m_active = 1'b1;
    end
    m_in_done = done_exp;
    @(posedge clk);
    #1;
    cyc++;
    if (done) done_cnt++;
    chk("cdt_avail", 128'(avail), 128'(m_credit));
    chk("cdt_err", 128'(err), 128'(m_err));
    chk("op_done", 128'(done), 128'(done_exp));
    chk("op_busy", 128'(busy), 128'(m_active));
    if (hold) begin
      chk("hold_vld", 128'(vld), 128'(1));
      chk("hold_pd", 128'(pd), 128'(pd_pre));
    end
    if (vld) chk("vld_legal", 128'(m_active && m_issued < m_total && m_credit > 0), 128'(1));
  endtask

  task automatic start_op(input int n, input logic [63:0] base);
    op_en        = 1'b1;
    op_req_num   = LW'(n);
    op_base_addr = base;
    tick();
    op_en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int i;
    d0 = done_cnt;
    i  = 0;
    while (done_cnt == d0 && i < budget) begin
      tick();
      i++;
    end
    if (done_cnt == d0) chk("done_timeout", 128'(0), 128'(1));
    tick();
  endtask

  int a0;
  int guard;

  initial begin
    rst_n = 1'b0; op_en = 1'b0; op_req_num = '0; op_base_addr = '0;
    rdy = 1'b0; pop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_vld", 128'(vld), 128'(0));
    chk("rst_pd", 128'(pd), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_avail", 128'(avail), 128'(DEPTH));

    // basic op: 4 back-to-back requests, credits returned 5 cycles later
    ret_on = 1'b1; rdy_fix = 1'b1;
    start_op(4, 64'h1000);
    chk("lat_vld_c1", 128'(vld), 128'(0));
    tick();
    chk("lat_vld_c2", 128'(vld), 128'(1));
    a0 = acc_cnt;
    repeat (4) tick();
    chk("b2b_accepts", 128'(acc_cnt - a0), 128'(4));
    wait_done(50);
    chk("basic_avail", 128'(avail), 128'(DEPTH));

    // credit stall: 10 requests, no returns
    ret_on = 1'b0;
    a0 = acc_cnt;
    start_op(10, 64'h2000);
    repeat (10) tick();
    chk("stall_accepts", 128'(acc_cnt - a0), 128'(DEPTH));
    chk("stall_vld", 128'(vld), 128'(0));
    chk("stall_avail", 128'(avail), 128'(0));
    chk("stall_busy", 128'(busy), 128'(1));
    pop_force = 1'b1;
    tick();
    pop_force = 1'b0;
    repeat (5) tick();
    chk("one_pop_accept", 128'(acc_cnt - a0), 128'(DEPTH + 1));
    ret_on = 1'b1;
    wait_done(100);

    // backpressure: hold rdy low 7 cycles while a request is pending
    rdy_fix = 1'b0;
    start_op(3, 64'h3000);
    guard = 0;
    while (!vld && guard < 10) begin tick(); guard++; end
    chk("bp_vld_seen", 128'(vld), 128'(1));
    a0 = acc_cnt;
    repeat (7) tick();
    chk("bp_no_accept", 128'(acc_cnt - a0), 128'(0));
    rdy_fix = 1'b1;
    tick();
    chk("bp_accept", 128'(acc_cnt - a0), 128'(1));
    wait_done(100);

    // accept and pop in the same cycle with one credit left
    ret_on = 1'b0;
    start_op(6, 64'h4000);
    guard = 0;
    while (!(vld && avail == CW'(1)) && guard < 20) begin tick(); guard++; end
    chk("c1_reached", 128'(avail), 128'(1));
    pop_force = 1'b1;
    tick();
    pop_force = 1'b0;
    chk("c1_avail_kept", 128'(avail), 128'(1));
    chk("c1_vld_next", 128'(vld), 128'(1));
    ret_on = 1'b1;
    wait_done(100);

    // address wrap at 2^64, with op_en pulsed while running
    start_op(2, 64'hFFFF_FFFF_FFFF_FFC0);
    op_en = 1'b1; op_req_num = LW'(5); op_base_addr = 64'h9000;
    tick();
    chk("wrap_pd1", 128'(pd), 128'({15'd1, 64'hFFFF_FFFF_FFFF_FFC0}));
    tick();
    chk("wrap_pd2", 128'(pd), 128'({15'd1, 64'h0}));
    op_en = 1'b0;
    wait_done(50);

    // empty operation
    a0 = acc_cnt;
    start_op(0, 64'h5000);
    chk("empty_done", 128'(done), 128'(1));
    tick();
    tick();
    chk("empty_no_req", 128'(acc_cnt - a0), 128'(0));

    // randomized operations: random rdy, random return latency
    rdy_rand = 1'b1; ret_min = 1; ret_max = 8;
    for (int k = 0; k < 8; k++) begin
      start_op(int'($urandom_range(12, 0)), {$urandom, $urandom_range(32'hFFFF_FFFF, 0) & 32'hFFFF_FFC0});
      wait_done(400);
      repeat (int'($urandom_range(3, 0))) tick();
    end
    rdy_rand = 1'b0; rdy_fix = 1'b1;
    repeat (12) tick();
    chk("rand_avail", 128'(avail), 128'(DEPTH));

    // surplus pop in IDLE with a full pool
    pop_raw = 1'b1;
    tick();
    pop_raw = 1'b0;
    tick();
    chk("ovf_avail", 128'(avail), 128'(DEPTH));
    chk("ovf_err", 128'(err), 128'(1));

    // reset in the middle of an operation
    ret_on = 1'b0; rdy_fix = 1'b0;
    start_op(8, 64'h6000);
    guard = 0;
    while (!vld && guard < 10) begin tick(); guard++; end
    chk("mid_vld_seen", 128'(vld), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 128'(vld), 128'(0));
    chk("mid_rst_avail", 128'(avail), 128'(DEPTH));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_err", 128'(err), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_credit = DEPTH; m_out = 0; m_err = 1'b0; m_active = 1'b0; m_in_done = 1'b0;
    ret_q.delete();
    a0 = done_cnt;
    rdy_fix = 1'b1;
    repeat (10) tick();
    chk("mid_no_done", 128'(done_cnt - a0), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
